demux14_buf: RTL
================

// Module: demux14_buf
// PURPOSE
//   Registered 1-to-4 demultiplexer with valid/ready handshake. It is the
//   distribution-side counterpart of the 4:1 select mux. One input word is
//   steered to one of four output channels by sel, and each output has a
//   1-entry holding register.
//   Used to fan a single producer (e.g. adder result bus) out to four
//   independent consumers that may stall individually.
// PARAMETERS
//   WIDTH   4   data width of input word and each output channel
//   CNT_W   8   width of per-channel accepted-word counters (wrap-around)
// PORTS
//   clk         in   1          clock, all state updates on rising edge
//   rst_n       in   1          synchronous reset, active low
//   sel         in   2          destination channel: 00->a, 01->b, 10->c, 11->d
//   in_data     in   WIDTH      input word
//   in_valid    in   1          input word present
//   in_ready    out  1          block can accept the word addressed by sel
//   out_data    out  4*WIDTH    {d,c,b,a}; channel k at [k*WIDTH +: WIDTH]
//   out_valid   out  4          per-channel holding register full
//   out_ready   in   4          per-channel consumer accepts
//   cnt_flat    out  4*CNT_W    per-channel count of accepted words, same packing
// BEHAVIOUR
//   Reset (rst_n==0 at a clk edge)
//     - out_valid=0, out_data=0, cnt_flat=0.
//     - rst_n has priority over every other event; mid-transfer words are discarded.
//   in_ready (combinational)
//     - in_ready = !out_valid[sel] | out_ready[sel].
//     - It depends only on the selected channel; other channels never stall the input.
//     - in_ready is not gated by in_valid.
//   Load
//     - Occurs when in_valid & in_ready at a clk edge (k = sel).
//     - out_data[k] <= in_data, out_valid[k] <= 1, cnt[k] <= cnt[k]+1 mod 2^CNT_W.
//     - Latency in->out is 1 cycle.
//     - sel and in_data are sampled only on a load; X on sel while in_valid=0 is legal.
//   Drain
//     - Occurs when out_valid[k] & out_ready[k] at a clk edge.
//     - Channel k clears out_valid[k] unless it loads in the same cycle.
//     - out_data[k] holds its last value after a drain; it is not cleared.
//   Same-cycle drain and load on channel k
//     - out_valid[k] stays 1 and out_data[k] takes the new word.
//     - This gives full throughput of 1 word/cycle per channel.
//   Other channels drain independently in the same cycle as a load to k.
//   Stability
//     - While out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
//   No per-channel state machine beyond out_valid[k] (EMPTY=0 / FULL=1).
//     - EMPTY->FULL on load.
//     - FULL->EMPTY on drain without load.
//     - FULL->FULL on hold, or on drain with load.
//   Counter wrap
//     - cnt[k] wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
//   1. Reset
//      - Hold rst_n=0 for 2 cycles with in_valid=1.
//      - Expect out_valid=4'b0000, out_data=0, cnt=0, and no load.
//   2. Single route
//      - Drive sel=2'b10, in_data=4'hA, in_valid=1 for one cycle, out_ready=0.
//      - Next cycle expect out_valid=4'b0100 and c=4'hA.
//      - Expect in_ready=0 while sel=10, and in_ready=1 for sel=00.
//   3. Back-pressure isolation
//      - Fill channel b; hold out_ready[1]=0.
//      - Stream 4'h1..4'h3 to sel=00 with out_ready[0]=1.
//      - Expect all accepted, b unchanged, and cnt_b=1, cnt_a=3.
//   4. Full throughput
//      - Send sel=11 for 8 consecutive cycles with out_ready[3]=1.
//      - Expect in_ready=1 every cycle and d equal to each word 1 cycle later.
//      - Expect cnt_d=8.
//   5. Reset mid-operation
//      - Fill all four channels, then pulse rst_n=0 for 1 cycle.
//      - Expect out_valid=0 and all counters 0.
//      - First load after reset sets cnt=1.
//   6. Counter wrap
//      - Load channel a 256 times with CNT_W=8.
//      - Expect cnt_a=0 and out_valid[0] unaffected by the wrap.

Source files
------------

// File: rtl/demux14_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux14_buf
//  Purpose  : Registered 1-to-4 demultiplexer with valid/ready handshake and
//             a one-entry holding register plus accepted-word counter per channel.
//  Revision : 1.0  initial release
// ============================================================================
module demux14_buf #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           sel,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*CNT_W-1:0]   cnt_flat
);

    logic w_load;

    // Only the addressed channel can stall the producer.
    assign in_ready = !out_valid[sel] | out_ready[sel];
    assign w_load   = in_valid & in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        logic             w_load_k;
        logic [WIDTH-1:0] r_data;
        logic             r_valid;
        logic [CNT_W-1:0] r_cnt;

        assign w_load_k = w_load && (sel == 2'(k));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else if (w_load_k) begin
                // A load wins over a same-cycle drain, keeping the slot full.
                r_data  <= in_data;
                r_valid <= 1'b1;
                r_cnt   <= r_cnt + CNT_W'(1);
            end else if (out_ready[k]) begin
                r_valid <= 1'b0;
            end
        end

        assign out_data[k*WIDTH +: WIDTH] = r_data;
        assign out_valid[k]               = r_valid;
        assign cnt_flat[k*CNT_W +: CNT_W] = r_cnt;
    end

endmodule
`default_nettype wire
